rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
Arbitrates the single RTC bus protocol engine among three requesters: the power-up/reset initialiser (req0), the write/edit machine (req1) and the permanent read machine (req2).
- Serialises one transaction at a time.
- Routes read data back to the granted requester.
- Guarantees forward progress for the read machine.
- Recovers from a hung engine with a timeout.

Sits between the requester FSMs and the protocol engine. It replaces the ad-hoc address/data muxing at top level.

Parameters:
MAX_CONSEC, 4, consecutive grants to req0/req1 allowed while req2 is pending before req2 is forced.
TIMEOUT, 1024, cycles in WAIT without cmd_done before the transaction aborts.
TW, 11, width of the timeout counter (must hold TIMEOUT).

Ports:
clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
req0,req1,req2  in  1 each  transaction request; held high until the matching ack
wr0,wr1,wr2  in  1 each  1 = write, 0 = read; stable while req is high
addr0,addr1,addr2  in  8 each  RTC register address
wdata0,wdata1,wdata2  in  8 each  write data
ack0,ack1,ack2  out  1 each  one-cycle completion pulse to the requester
rdata  out  8  read data, valid only in the ack cycle
err  out  1  pulses with ack when the transaction timed out
grant  out  2  current owner 0/1/2; 2'b11 = none
busy  out  1  high whenever state != IDLE
cmd_start  out  1  one-cycle start pulse to the protocol engine
cmd_write  out  1  transaction type to the engine
cmd_addr  out  8  address to the engine
cmd_wdata  out  8  write data to the engine
cmd_done  in  1  engine completion pulse
cmd_rdata  in  8  engine read data, valid with cmd_done

Behaviour:
Reset values (asynchronous):
- state = IDLE; grant = 2'b11.
- busy, cmd_start, ack0-2 and err = 0.
- rdata, cmd_addr, cmd_wdata and cmd_write = 0.
- starvation counter and timeout counter = 0.

Reset asserted mid-transaction aborts it silently: no ack is produced, and the engine is expected to be reset by the same signal.

FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - On a clock edge with any req high, select the winner.
  - Register grant, cmd_addr, cmd_wdata and cmd_write from the winner's inputs.
  - Go to ISSUE.
- ISSUE:
  - cmd_start = 1 for exactly this cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - If cmd_done = 1: capture cmd_rdata into rdata (writes also capture it; the requester ignores it); go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 without done: rdata = 8'h00, set an abort flag, go to RESP.
- RESP:
  - ack[grant] = 1 for one cycle; err = abort flag.
  - Clear the abort flag, set grant = 2'b11, go to IDLE.

Registered outputs and latency:
- All outputs are registered.
- The req-to-cmd_start latency is 2 edges: the sampling edge, then ISSUE asserted.
- Minimum req-to-ack is 4 cycles, given cmd_done in the first WAIT cycle.
- cmd_done seen outside WAIT is ignored.

Selection order:
- Fixed priority req0 > req1 > req2, with one exception: if req2 is high and the starvation counter equals MAX_CONSEC, req2 wins regardless.
- The counter increments on each grant to req0/req1 while req2 is high.
- It clears on a grant to req2, or whenever req2 is low in IDLE.
- It saturates at MAX_CONSEC.

Handshake rules:
- A requester holds req, wr, addr and wdata stable until its ack.
- It may drop req in the ack cycle.
- If req is still high when the FSM is back in IDLE, that is a new transaction; back-to-back transactions are therefore spaced by at least one IDLE cycle.

Other rules:
- Inputs of non-granted requesters are never forwarded.
- Exactly one ack is asserted at a time.

Test Plan:
1. Single read: req2=1, wr2=0, addr2=8'h21; engine returns cmd_done with cmd_rdata=8'h45 three cycles after cmd_start -> cmd_addr=21, cmd_write=0, one cmd_start pulse; ack2 with rdata=45 and err=0; grant returns to 11.
2. Simultaneous requests: req0 (write 8'h02 to addr 8'h02), req1 and req2 all high at once -> served in order 0, 1, 2; each ack is a single cycle; no overlap of cmd_start.
3. Starvation guard: req1 and req2 held high continuously with MAX_CONSEC=4 -> grant sequence 1,1,1,1,2,1,1,1,1,2.
4. Timeout: req1 write with cmd_done never asserted -> after TIMEOUT cycles in WAIT, ack1=1, err=1, rdata=00; the next request is served normally.
5. Reset mid-WAIT: assert Reset during WAIT of a req2 read -> outputs immediately reach reset values with no ack; after release, re-held req2 restarts with a fresh cmd_start.
6. Spurious cmd_done: pulse cmd_done while IDLE -> no ack and no state change.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates the RTC bus protocol engine among the initialiser, the write/edit machine and
// the read machine, one transaction at a time.
module rtc_bus_arbiter #(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned TW         = 11
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       wr0,
    input  logic       wr1,
    input  logic       wr2,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] wdata2,
    output logic       ack0,
    output logic       ack1,
    output logic       ack2,
    output logic [7:0] rdata,
    output logic       err,
    output logic [1:0] grant,
    output logic       busy,
    output logic       cmd_start,
    output logic       cmd_write,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_wdata,
    input  logic       cmd_done,
    input  logic [7:0] cmd_rdata
);

    localparam int unsigned SW = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [SW-1:0] starv_q, starv_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          abort_q, abort_d;
    logic [2:0]    ack_q, ack_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    cmd_addr_q, cmd_addr_d;
    logic [7:0]    cmd_wdata_q, cmd_wdata_d;
    logic          cmd_write_q, cmd_write_d;
    logic          cmd_start_q, cmd_start_d;
    logic          busy_q, busy_d;
    logic [1:0]    win;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        starv_d     = starv_q;
        tmo_d       = tmo_q;
        abort_d     = abort_q;
        ack_d       = 3'b000;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_write_d = cmd_write_q;
        win         = 2'd2;

        // The read machine is forced through once it has been passed over MAX_CONSEC times.
        if (req2 && starv_q == SW'(MAX_CONSEC)) begin
            win = 2'd2;
        end else if (req0) begin
            win = 2'd0;
        end else if (req1) begin
            win = 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!req2) begin
                    starv_d = '0;
                end
                if (req0 || req1 || req2) begin
                    state_d = StIssue;
                    grant_d = win;
                    if (win == 2'd2) begin
                        starv_d = '0;
                    end else if (req2 && starv_q != SW'(MAX_CONSEC)) begin
                        starv_d = starv_q + SW'(1);
                    end
                    case (win)
                        2'd0: begin
                            cmd_addr_d  = addr0;
                            cmd_wdata_d = wdata0;
                            cmd_write_d = wr0;
                        end
                        2'd1: begin
                            cmd_addr_d  = addr1;
                            cmd_wdata_d = wdata1;
                            cmd_write_d = wr1;
                        end
                        default: begin
                            cmd_addr_d  = addr2;
                            cmd_wdata_d = wdata2;
                            cmd_write_d = wr2;
                        end
                    endcase
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (cmd_done) begin
                    rdata_d = cmd_rdata;
                    ack_d   = 3'b001 << grant_q;
                    state_d = StResp;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rdata_d = 8'h00;
                    abort_d = 1'b1;
                    ack_d   = 3'b001 << grant_q;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StResp: begin
                abort_d = 1'b0;
                grant_d = 2'b11;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        cmd_start_d = (state_d == StIssue);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            grant_q     <= 2'b11;
            starv_q     <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
            ack_q       <= 3'b000;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            cmd_addr_q  <= 8'h00;
            cmd_wdata_q <= 8'h00;
            cmd_write_q <= 1'b0;
            cmd_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            starv_q     <= starv_d;
            tmo_q       <= tmo_d;
            abort_q     <= abort_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_write_q <= cmd_write_d;
            cmd_start_q <= cmd_start_d;
            busy_q      <= busy_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign ack2      = ack_q[2];
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign cmd_start = cmd_start_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized bench for rtc_bus_arbiter: requesters and engine are driven here and every
// transaction is checked against a transaction-level model of the selection rules.
module tb_rtc_bus_arbiter;

    localparam int unsigned MAX_CONSEC = 4;
    localparam int unsigned TIMEOUT    = 1024;
    localparam int unsigned TW         = 11;

    logic       clk = 1'b0;
    logic       Reset;
    logic [2:0] req_v;
    logic [2:0] wr_v;
    logic [7:0] addr_v [3];
    logic [7:0] wdata_v[3];
    logic       ack0, ack1, ack2, err, busy, cmd_start, cmd_write, cmd_done;
    logic [7:0] rdata, cmd_addr, cmd_wdata, cmd_rdata;
    logic [1:0] grant;

    int n_tests = 0;
    int n_fail  = 0;
    int remain[3];
    int starv;

    always #5 clk = ~clk;

    rtc_bus_arbiter #(
        .MAX_CONSEC(MAX_CONSEC),
        .TIMEOUT   (TIMEOUT),
        .TW        (TW)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .req0     (req_v[0]),
        .req1     (req_v[1]),
        .req2     (req_v[2]),
        .wr0      (wr_v[0]),
        .wr1      (wr_v[1]),
        .wr2      (wr_v[2]),
        .addr0    (addr_v[0]),
        .addr1    (addr_v[1]),
        .addr2    (addr_v[2]),
        .wdata0   (wdata_v[0]),
        .wdata1   (wdata_v[1]),
        .wdata2   (wdata_v[2]),
        .ack0     (ack0),
        .ack1     (ack1),
        .ack2     (ack2),
        .rdata    (rdata),
        .err      (err),
        .grant    (grant),
        .busy     (busy),
        .cmd_start(cmd_start),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_done (cmd_done),
        .cmd_rdata(cmd_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i);
        wr_v[i]    = 1'($urandom_range(0, 1));
        addr_v[i]  = 8'($urandom);
        wdata_v[i] = 8'($urandom);
    endtask

    // Who should win the next arbitration, given which requesters still have work queued.
    task automatic predict(output int w);
        bit p2;
        p2 = remain[2] > 0;
        if (!p2) starv = 0;
        if (p2 && starv == int'(MAX_CONSEC)) w = 2;
        else if (remain[0] > 0) w = 0;
        else if (remain[1] > 0) w = 1;
        else w = 2;
        if (w == 2) starv = 0;
        else if (p2 && starv < int'(MAX_CONSEC)) starv++;
    endtask

    // mode: 0 = random engine delay (occasionally hung), >0 = fixed delay, <0 = engine hangs.
    task automatic do_txn(input int w, input int mode, output bit ok);
        int         d;
        int         k;
        int         stray;
        bit         hang;
        bit         seen;
        logic [7:0] rd;
        logic [2:0] exp_ack;
        ok   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cmd_start) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("start_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check_eq("grant", 32'(grant), 32'(w));
        check_eq("cmd_write", 32'(cmd_write), 32'(wr_v[w]));
        check_eq("cmd_addr", 32'(cmd_addr), 32'(addr_v[w]));
        check_eq("cmd_wdata", 32'(cmd_wdata), 32'(wdata_v[w]));
        check_eq("busy_txn", 32'(busy), 32'd1);

        d = 1;
        if (mode < 0) begin
            hang = 1'b1;
        end else if (mode > 0) begin
            hang = 1'b0;
            d    = mode;
        end else begin
            hang = ($urandom_range(0, 29) == 0);
            d    = int'($urandom_range(1, 5));
        end
        rd    = 8'($urandom);
        seen  = 1'b0;
        stray = 0;
        k     = 0;
        while (k < int'(TIMEOUT) + 8) begin
            @(negedge clk);
            k++;
            if (ack0 || ack1 || ack2) begin
                seen = 1'b1;
                break;
            end
            if (cmd_start) stray++;
            cmd_done  = !hang && (k == d);
            cmd_rdata = cmd_done ? rd : 8'($urandom);
        end
        cmd_done = 1'b0;
        check_eq("ack_seen", 32'(seen), 32'd1);
        check_eq("stray_start", 32'(stray), 32'd0);
        if (!seen) return;
        exp_ack = 3'b001 << w;
        check_eq("ack_latency", 32'(k), hang ? 32'(TIMEOUT + 1) : 32'(d + 1));
        check_eq("ack_vec", 32'({ack2, ack1, ack0}), 32'(exp_ack));
        check_eq("rdata", 32'(rdata), hang ? 32'd0 : 32'(rd));
        check_eq("err", 32'(err), 32'(hang));

        remain[w]--;
        if (remain[w] > 0) load(w);
        else req_v[w] = 1'b0;

        @(negedge clk);
        check_eq("ack_single", 32'({ack2, ack1, ack0}), 32'd0);
        check_eq("grant_idle", 32'(grant), 32'd3);
        check_eq("busy_idle", 32'(busy), 32'd0);
        ok = 1'b1;
    endtask

    task automatic run_round(input int c0, input int c1, input int c2, input int mode);
        int w;
        bit ok;
        remain[0] = c0;
        remain[1] = c1;
        remain[2] = c2;
        starv     = 0;
        for (int i = 0; i < 3; i++) begin
            if (remain[i] > 0) begin
                load(i);
                req_v[i] = 1'b1;
            end
        end
        while (remain[0] + remain[1] + remain[2] > 0) begin
            predict(w);
            do_txn(w, mode, ok);
            if (!ok) begin
                req_v = 3'b000;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 32'd3);
        check_eq({tag, "_ctl"}, 32'({busy, cmd_start, ack2, ack1, ack0, err, cmd_write}), 32'd0);
        check_eq({tag, "_data"}, 32'({rdata, cmd_addr, cmd_wdata}), 32'd0);
    endtask

    initial begin
        bit ok;
        Reset     = 1'b1;
        req_v     = 3'b000;
        wr_v      = 3'b000;
        cmd_done  = 1'b0;
        cmd_rdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            addr_v[i]  = 8'h00;
            wdata_v[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        Reset = 1'b0;
        @(negedge clk);

        run_round(0, 0, 1, 3);      // single read
        run_round(1, 1, 1, 1);      // simultaneous requests
        run_round(0, 10, 2, 1);     // starvation guard: 1,1,1,1,2,1,1,1,1,2
        run_round(3, 6, 3, 0);
        run_round(0, 1, 0, -1);     // engine hang
        run_round(0, 1, 0, 1);

        // Spurious done while idle must not disturb anything.
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("spurious_busy", 32'(busy), 32'd0);
            check_eq("spurious_ack", 32'({ack2, ack1, ack0, cmd_start}), 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of a read, then the held request restarts cleanly.
        load(2);
        wr_v[2]  = 1'b0;
        req_v[2] = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cmd_start) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rst_pre_start", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        check_reset_vals("midreset_hold");
        Reset     = 1'b0;
        remain[0] = 0;
        remain[1] = 0;
        remain[2] = 1;
        starv     = 0;
        do_txn(2, 2, ok);
        req_v = 3'b000;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            int c0, c1, c2;
            c0 = int'($urandom_range(0, 3));
            c1 = int'($urandom_range(0, 6));
            c2 = int'($urandom_range(0, 3));
            if (c0 + c1 + c2 == 0) c2 = 1;
            run_round(c0, c1, c2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
